// File: rtl/uart_tx_feeder_pkg.sv
// Shared UART feeder definitions: FSM state encoding and WAIT_BUSY timeout.
package uart_tx_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } feeder_state_e;

  // Cycles to wait for the transmitter to raise busy before assuming it is done.
  localparam int unsigned WaitBusyTimeout = 4;
  localparam int unsigned WaitCntW        = $clog2(WaitBusyTimeout);
  localparam logic [WaitCntW-1:0] WaitCntLast = WaitCntW'(WaitBusyTimeout - 1);

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy level; pointers wrap naturally
// because DEPTH is a power of two.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic              do_push;
  logic              do_pop;

  assign full     = (level_q == LevelW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem[rd_ptr_q];

  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and level bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter one strobe at a time, waiting for
// the transmitter's busy flag to rise and fall between bytes.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  output logic                   tx_en,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  feeder_state_e         state_q;
  logic [WaitCntW-1:0]   wait_cnt_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [DATA_W-1:0]     head_data;
  logic                  push;
  logic                  pop;

  assign wr_ready = !fifo_full;
  assign empty    = fifo_empty;
  assign level    = fifo_level;
  assign push     = wr_valid && wr_ready;
  // The head is consumed in the same cycle it is latched into tx_data.
  assign pop      = (state_q == StIdle) && !fifo_empty && !tx_busy;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Handshake FSM with registered strobe and data outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      tx_en      <= 1'b0;
      tx_data    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tx_en   <= 1'b1;
            tx_data <= head_data;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          tx_en      <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= StWaitBusy;
        end
        StWaitBusy: begin
          // Busy never rising means the transmitter finished or dropped the byte.
          if (tx_busy) begin
            state_q <= StWaitDone;
          end else if (wait_cnt_q == WaitCntLast) begin
            state_q <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (wr_valid && !wr_ready) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: a queue-based model predicts accepted
// bytes, level and overflow; a negedge monitor checks every strobe and flag.
module tb_uart_tx_feeder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              tx_en;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic [4:0]        level;
  logic              empty;
  logic              overflow;
  logic              ovf_clr;

  uart_tx_feeder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .level    (level),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state.
  int              acc_cnt = 0;
  int              pop_cnt = 0;
  logic [7:0]      exp_q[$];
  bit              exp_ovf = 0;
  bit              last_accept = 0;
  bit              rst_edge = 0;
  bit              started = 0;
  bit              prev_busy = 0;
  bit              m_full;
  int              strobe_cyc[$];

  // Monitor state.
  bit              prev_tx_en = 0;
  logic [7:0]      last_data = 0;
  logic [7:0]      exp_b;

  // Transmitter model: 0 = never busy, 1 = always busy, 2 = busy for a hold time per byte.
  int              tx_mode = 0;
  bit              model_busy = 0;
  int              busy_cnt = 0;
  int              hold_max = 10;
  bit              hold_rand = 0;
  int              hold;

  assign tx_busy = (tx_mode == 0) ? 1'b0 : (tx_mode == 1) ? 1'b1 : model_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: decide acceptance and overflow from occupancy before this edge.
  always @(posedge clk) begin
    cyc++;
    started = 1;
    prev_busy = tx_busy;
    last_accept = 0;
    if (!resetn) begin
      acc_cnt = pop_cnt;
      exp_q.delete();
      exp_ovf = 0;
      rst_edge = 1;
    end else begin
      rst_edge = 0;
      m_full = (acc_cnt - pop_cnt) >= DEPTH;
      if (wr_valid && !m_full) begin
        acc_cnt++;
        exp_q.push_back(wr_data);
        last_accept = 1;
      end
      if (wr_valid && m_full) exp_ovf = 1;
      else if (ovf_clr) exp_ovf = 0;
    end
  end

  // Monitor: compare strobes and status against the model.
  always @(negedge clk) begin
    if (started) begin
      if (rst_edge) begin
        prev_tx_en = 0;
        last_data = 0;
      end
      if (tx_en === 1'b1) begin
        check("strobe_after_busy_low", 32'(prev_busy), 0);
        check("strobe_single_cycle", 32'(prev_tx_en), 0);
        check("strobe_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(exp_b));
          pop_cnt++;
        end
        last_data = tx_data;
        strobe_cyc.push_back(cyc);
      end else begin
        check("tx_data_hold", 32'(tx_data), 32'(last_data));
      end
      prev_tx_en = (tx_en === 1'b1);
      check("level", 32'(level), 32'(acc_cnt - pop_cnt));
      check("empty", 32'(empty), 32'(acc_cnt == pop_cnt));
      check("wr_ready", 32'(wr_ready), 32'((acc_cnt - pop_cnt) < DEPTH));
      check("overflow", 32'(overflow), 32'(exp_ovf));
    end
  end

  // Transmitter model, updated away from the active edge.
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      hold = hold_rand ? int'($urandom_range(0, hold_max)) : hold_max;
      model_busy = (hold > 0);
      busy_cnt = hold;
    end else if (model_busy) begin
      busy_cnt--;
      if (busy_cnt <= 0) model_busy = 0;
    end
  end

  // Call at a negedge; returns at the negedge after the byte was accepted.
  task automatic write_byte(input logic [7:0] d);
    int n;
    n = 0;
    wr_valid = 1;
    wr_data = d;
    @(negedge clk);
    while (!last_accept && n < 500) begin
      @(negedge clk);
      n++;
    end
    wr_valid = 0;
    check("write_accepted", 32'(last_accept), 1);
  endtask

  task automatic write_once(input logic [7:0] d);
    wr_valid = 1;
    wr_data = d;
    @(negedge clk);
    wr_valid = 0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    check("drain_done", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    resetn = 0;
    wr_valid = 0;
    wr_data = 0;
    ovf_clr = 0;
    repeat (3) @(negedge clk);
    check("reset_level", 32'(level), 0);
    check("reset_tx_en", 32'(tx_en), 0);
    check("reset_tx_data", 32'(tx_data), 0);
    check("reset_wr_ready", 32'(wr_ready), 1);
    resetn = 1;
    @(negedge clk);

    // Single byte into an idle feeder: strobe two cycles after the write.
    tx_mode = 0;
    wr_valid = 1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_valid = 0;
    check("latency_cycle1_tx_en", 32'(tx_en), 0);
    @(negedge clk);
    check("latency_cycle2_tx_en", 32'(tx_en), 1);
    check("latency_tx_data", 32'(tx_data), 32'h A5);
    repeat (10) @(negedge clk);
    check("a5_level_back_to_0", 32'(level), 0);

    // Busy never rises: strobes spaced by issue + 4 wait + idle cycles.
    strobe_cyc.delete();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    drain(200);
    check("timeout_strobes", 32'(strobe_cyc.size()), 3);
    if (strobe_cyc.size() == 3) begin
      check("timeout_gap1", 32'(strobe_cyc[1] - strobe_cyc[0]), 6);
      check("timeout_gap2", 32'(strobe_cyc[2] - strobe_cyc[1]), 6);
    end

    // Transmitter busy for 10 cycles per byte.
    tx_mode = 2;
    hold_rand = 0;
    hold_max = 10;
    strobe_cyc.delete();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    drain(400);
    check("busy10_strobes", 32'(strobe_cyc.size()), 3);

    // Fill with busy held high, then overflow and clear.
    tx_mode = 1;
    for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h40 + i));
    check("full_level", 32'(level), 16);
    check("full_wr_ready", 32'(wr_ready), 0);
    write_once(8'hEE);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_level_unchanged", 32'(level), 16);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    check("ovf_cleared", 32'(overflow), 0);

    // Pop and write in the same cycle while full: write rejected.
    wr_valid = 1;
    wr_data = 8'h77;
    tx_mode = 0;
    @(negedge clk);
    wr_valid = 0;
    tx_mode = 1;
    check("pop_while_full_level", 32'(level), 15);
    check("pop_while_full_tx_en", 32'(tx_en), 1);
    check("pop_while_full_ovf", 32'(overflow), 1);
    write_once(8'h88);
    check("refill_level", 32'(level), 16);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    tx_mode = 2;
    hold_max = 2;
    drain(2000);

    // 20 random bytes across pointer wrap with a real transmitter.
    hold_max = 3;
    strobe_cyc.delete();
    for (int i = 0; i < 20; i++) write_byte(8'($urandom));
    drain(2000);
    check("wrap_strobes", 32'(strobe_cyc.size()), 20);

    // Randomized traffic with random transmitter hold times.
    hold_rand = 1;
    hold_max = 8;
    for (int i = 0; i < 600; i++) begin
      wr_valid = ($urandom % 2) == 0;
      wr_data = 8'($urandom);
      ovf_clr = ($urandom % 10) == 0;
      @(negedge clk);
    end
    wr_valid = 0;
    ovf_clr = 0;
    drain(5000);

    // Reset while waiting on a busy transmitter with 5 bytes queued.
    hold_rand = 0;
    hold_max = 40;
    for (int i = 0; i < 6; i++) write_byte(8'(8'hC0 + i));
    repeat (3) @(negedge clk);
    check("pre_reset_level", 32'(level), 5);
    check("pre_reset_busy", 32'(tx_busy), 1);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    check("post_reset_level", 32'(level), 0);
    check("post_reset_tx_en", 32'(tx_en), 0);
    check("post_reset_empty", 32'(empty), 1);
    strobe_cyc.delete();
    repeat (60) @(negedge clk);
    check("post_reset_no_strobes", 32'(strobe_cyc.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width matching the downstream transmitter.
REQ-002 SHALL have parameter DEPTH, default 16, number of FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port wr_valid  input  1  producer offers wr_data this cycle.
REQ-006 SHALL have port wr_data  input  DATA_W  byte to queue.
REQ-007 SHALL have port wr_ready  output  1  FIFO not full; a write is accepted when wr_valid and wr_ready are both high.
REQ-008 SHALL have port tx_en  output  1  one-cycle send strobe to the transmitter.
REQ-009 SHALL have port tx_data  output  DATA_W  byte presented with tx_en, held until the next strobe.
REQ-010 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-012 SHALL have port empty  output  1  level == 0.
REQ-013 SHALL have port overflow  output  1  sticky flag: a write was attempted while full.
REQ-014 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-015 SHALL store entries in a DEPTH-entry circular buffer with $clog2(DEPTH)-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-016 SHALL combinationally derive wr_ready = (level != DEPTH), from registered state only.
REQ-017 SHALL, on an accepted write, store wr_data at the write pointer, advance the write pointer, and make the entry poppable on the next cycle.
REQ-018 SHALL use a 4-state FSM: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-019 In IDLE, when empty==0 and tx_busy==0, the block SHALL register tx_data = head entry and tx_en = 1, pop the head (advance the read pointer), and go to ISSUE.
REQ-020 In ISSUE, tx_en SHALL be high for exactly this one cycle; the register SHALL then return tx_en to 0 and go to WAIT_BUSY.
REQ-021 In WAIT_BUSY, the block SHALL go to WAIT_DONE when tx_busy==1; if tx_busy is still 0 after 4 cycles in this state, it SHALL return to IDLE (transmitter already finished or dropped the byte).
REQ-022 In WAIT_DONE, the block SHALL go to IDLE when tx_busy==0.
REQ-023 Latency SHALL be 2 cycles from an accepted write into an empty FIFO with an idle FSM to tx_en high.
REQ-024 Level update SHALL be: level + push - pop in one cycle; a simultaneous push and pop leaves level unchanged.
REQ-025 When full, wr_ready SHALL be 0 and no push SHALL occur, even if a pop happens in the same cycle.
REQ-026 overflow SHALL set on wr_valid && !wr_ready; ovf_clr SHALL clear it, and set SHALL take priority when both occur in the same cycle.
REQ-027 tx_data SHALL change only when tx_en is asserted.

Reset
REQ-028 On resetn==0 at a clock edge, the block SHALL set: pointers=0, level=0, empty=1, wr_ready=1, tx_en=0, tx_data=0, overflow=0, FSM=IDLE.
REQ-029 A reset during any state SHALL discard all queued bytes and any pending handshake; FIFO memory contents need not be cleared.

Structure
REQ-030 FSM state encodings and the WAIT_BUSY timeout constant (4) SHALL live in a shared UART package.
REQ-031 Storage and pointer/level logic SHALL be one sub-module, sync_fifo (push/pop/full/empty/level); the FSM and handshake logic SHALL live in uart_tx_feeder.

Verification
REQ-032 Reset, then write 0xA5 with tx_busy=0 -> tx_en high exactly 2 cycles after the write, tx_data=0xA5, level returns to 0.
REQ-033 Write 0x01,0x02,0x03 back-to-back while a transmitter model holds busy for 10 cycles per byte -> three single-cycle strobes in order 01,02,03, each strobe only after busy has fallen.
REQ-034 Write 16 bytes with tx_busy held at 1 -> level=16, wr_ready=0; a 17th write -> overflow=1 and the byte is not stored; ovf_clr -> overflow=0.
REQ-035 With the FIFO full, pop one entry and issue a write in the same cycle -> level=15 and the write is rejected; the next write is accepted and level=16.
REQ-036 Write 20 bytes with pointer wrap-around under a real transmitter model -> the serial output byte sequence equals the input sequence exactly.
REQ-037 Assert resetn=0 while in WAIT_DONE with 5 bytes queued -> next cycle FSM=IDLE, level=0, tx_en=0, and no further strobes occur.
